// File: rtl/phys_tag_alloc_ctrl.sv
// phys_tag_alloc_ctrl
// Physical register tag allocator. Free tags sit in a circular queue addressed
// by head (allocation) and tail (reclaim) pointers. After reset a sequencer
// fills the queue with every non-architectural tag, then the controller grants
// up to ALLOC_W tags and reclaims up to FREE_W tags per cycle. One checkpoint
// of the head pointer supports branch recovery.
//
// Optional build macro: PHYS_TAG_ALLOC_ERR_EN adds a sticky 'err' output that
// flags dropped frees, frees seen during INIT and out-of-range restores.
//
// Pointers wrap modulo 2*DEPTH so that a full queue (tail - head == DEPTH) and
// an empty one (tail == head) stay distinguishable when the occupancy has to
// be recomputed from pointers on a restore.

module phys_tag_alloc_ctrl #(
    parameter int PHYS_REGS  = 64,
    parameter int ARCH_REGS  = 32,
    parameter int TAG_W      = 6,
    parameter int ALLOC_W    = 2,
    parameter int FREE_W     = 2,
    localparam int DEPTH     = PHYS_REGS - ARCH_REGS,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ALLOC_W-1:0]         alloc_req,
    output logic [ALLOC_W-1:0]         alloc_gnt,
    output logic [ALLOC_W*TAG_W-1:0]   alloc_tag,
    input  logic [FREE_W-1:0]          free_vld,
    input  logic [FREE_W*TAG_W-1:0]    free_tag,
    input  logic                       ckpt_save,
    input  logic                       ckpt_restore,
    output logic                       ready,
    output logic [CNT_W-1:0]           free_count
`ifdef PHYS_TAG_ALLOC_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int SUM_W = PTR_W + 2;

    localparam logic [SUM_W-1:0] DEPTH_S   = SUM_W'(DEPTH);
    localparam logic [SUM_W-1:0] PTR_MOD_S = SUM_W'(2 * DEPTH);
    localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(DEPTH - 1);
    localparam logic [TAG_W-1:0] ARCH_TAG  = TAG_W'(ARCH_REGS);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_READY   = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Pointer helpers
    // ------------------------------------------------------------------

    // Advance a pointer by n entries, wrapping modulo 2*DEPTH.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [SUM_W-1:0] n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + n;
        s = (s >= PTR_MOD_S) ? (s - PTR_MOD_S) : s;
        return s[PTR_W-1:0];
    endfunction

    // Map a pointer onto a queue slot (modulo DEPTH).
    function automatic logic [IDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] p);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p);
        s = (s >= DEPTH_S) ? (s - DEPTH_S) : s;
        return s[IDX_W-1:0];
    endfunction

    // Number of entries from h up to t, modulo 2*DEPTH.
    function automatic logic [SUM_W-1:0] ptr_dist(input logic [PTR_W-1:0] t,
                                                  input logic [PTR_W-1:0] h);
        logic [SUM_W-1:0] d;
        d = (t >= h) ? (SUM_W'(t) - SUM_W'(h))
                     : (SUM_W'(t) + PTR_MOD_S - SUM_W'(h));
        return d;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;
    logic [PTR_W-1:0]   ckpt_head_q, ckpt_head_d;
    logic [TAG_W-1:0]   queue_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational datapath signals
    // ------------------------------------------------------------------
    logic               alloc_en_s;
    logic               free_en_s;
    logic [ALLOC_W-1:0] gnt_s;
    logic [ALLOC_W*TAG_W-1:0] tag_s;
    logic [SUM_W-1:0]   n_gnt_s;
    logic [SUM_W-1:0]   n_free_s;
    logic [SUM_W-1:0]   room_s;
    logic [FREE_W-1:0]  wr_en_s;
    logic [IDX_W-1:0]   wr_idx_s  [FREE_W];
    logic [TAG_W-1:0]   wr_data_s [FREE_W];
    logic [PTR_W-1:0]   head_next_s;
    logic [SUM_W-1:0]   restore_cnt_s;

    // Grants only in READY and never in a restore cycle; reset masks them so
    // nothing is granted on the edge that resets the block.
    assign alloc_en_s = reset && (state_q == ST_READY) && !ckpt_restore;
    // Frees are accepted in READY (including restore cycles) and RECOVER.
    assign free_en_s  = (state_q == ST_READY) || (state_q == ST_RECOVER);

    // Grant scan: each requesting slot takes the next unconsumed entry while
    // entries remain; idle slots do not consume an entry.
    always_comb begin
        gnt_s   = '0;
        tag_s   = '0;
        n_gnt_s = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_en_s && alloc_req[i] && (n_gnt_s < SUM_W'(count_q))) begin
                gnt_s[i]                  = 1'b1;
                tag_s[i*TAG_W +: TAG_W]   = queue_q[ptr_idx(ptr_add(head_q, n_gnt_s))];
                n_gnt_s                   = n_gnt_s + SUM_W'(1);
            end else begin
                gnt_s[i] = 1'b0;
            end
        end
    end

    // Free scan: accepted frees are packed at tail in slot order; once the
    // queue would exceed DEPTH the remaining (higher) slots are dropped.
    always_comb begin
        wr_en_s  = '0;
        n_free_s = '0;
        room_s   = DEPTH_S - SUM_W'(count_q) + n_gnt_s;
        for (int j = 0; j < FREE_W; j++) begin
            wr_idx_s[j]  = '0;
            wr_data_s[j] = '0;
        end
        for (int j = 0; j < FREE_W; j++) begin
            if (free_en_s && free_vld[j] && (n_free_s < room_s)) begin
                wr_en_s[j]   = 1'b1;
                wr_idx_s[j]  = ptr_idx(ptr_add(tail_q, n_free_s));
                wr_data_s[j] = free_tag[j*TAG_W +: TAG_W];
                n_free_s     = n_free_s + SUM_W'(1);
            end else begin
                wr_en_s[j] = 1'b0;
            end
        end
    end

    // Next-state and pointer/count update for the INIT/READY/RECOVER sequencer.
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        init_idx_d    = init_idx_q;
        ckpt_head_d   = ckpt_head_q;
        head_next_s   = ptr_add(head_q, n_gnt_s);
        restore_cnt_s = '0;
        case (state_q)
            ST_INIT: begin
                if (init_idx_q == INIT_LAST) begin
                    init_idx_d = '0;
                    tail_d     = ptr_add('0, DEPTH_S);
                    count_d    = CNT_W'(DEPTH);
                    state_d    = ST_READY;
                end else begin
                    init_idx_d = init_idx_q + IDX_W'(1);
                end
            end
            ST_READY: begin
                tail_d = ptr_add(tail_q, n_free_s);
                if (ckpt_restore) begin
                    restore_cnt_s = ptr_dist(tail_d, ckpt_head_q);
                    head_d        = ckpt_head_q;
                    count_d       = CNT_W'(restore_cnt_s);
                    state_d       = ST_RECOVER;
                end else begin
                    head_d  = head_next_s;
                    count_d = CNT_W'(SUM_W'(count_q) + n_free_s - n_gnt_s);
                    if (ckpt_save) begin
                        ckpt_head_d = head_next_s;
                    end else begin
                        ckpt_head_d = ckpt_head_q;
                    end
                end
            end
            ST_RECOVER: begin
                tail_d  = ptr_add(tail_q, n_free_s);
                count_d = CNT_W'(SUM_W'(count_q) + n_free_s);
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            init_idx_q  <= '0;
            ckpt_head_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            init_idx_q  <= init_idx_d;
            ckpt_head_q <= ckpt_head_d;
        end
    end

    // Queue storage: sequential fill during INIT, packed frees afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_q == ST_INIT) begin
                queue_q[init_idx_q] <= ARCH_TAG + TAG_W'(init_idx_q);
            end else begin
                for (int j = 0; j < FREE_W; j++) begin
                    if (wr_en_s[j]) begin
                        queue_q[wr_idx_s[j]] <= wr_data_s[j];
                    end
                end
            end
        end
    end

    assign alloc_gnt  = gnt_s;
    assign alloc_tag  = tag_s;
    assign ready      = (state_q == ST_READY);
    assign free_count = count_q;

`ifdef PHYS_TAG_ALLOC_ERR_EN
    // Count the valid bits of a free vector.
    function automatic logic [SUM_W-1:0] popcount(input logic [FREE_W-1:0] v);
        logic [SUM_W-1:0] c;
        c = '0;
        for (int j = 0; j < FREE_W; j++) begin
            c = c + SUM_W'(v[j]);
        end
        return c;
    endfunction

    logic err_q, err_d;
    logic drop_s, init_free_s, restore_ovf_s;

    assign drop_s        = free_en_s && (popcount(free_vld) > n_free_s);
    assign init_free_s   = (state_q == ST_INIT) && (|free_vld);
    assign restore_ovf_s = (state_q == ST_READY) && ckpt_restore && (restore_cnt_s > DEPTH_S);
    assign err_d         = err_q | drop_s | init_free_s | restore_ovf_s;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_phys_tag_alloc_ctrl.sv
// Directed testbench for phys_tag_alloc_ctrl (default parameters: 64 phys,
// 32 arch, 2 alloc slots, 2 free slots). Inputs change on the falling edge;
// registered outputs are checked at the falling edge and combinational grant
// outputs 1 time unit after the inputs settle.

module tb_phys_tag_alloc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alloc_req;
    logic [1:0]  alloc_gnt;
    logic [11:0] alloc_tag;
    logic [1:0]  free_vld;
    logic [11:0] free_tag;
    logic        ckpt_save;
    logic        ckpt_restore;
    logic        ready;
    logic [5:0]  free_count;
`ifdef PHYS_TAG_ALLOC_ERR_EN
    logic        err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_tags[$];

    phys_tag_alloc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_tag    (alloc_tag),
        .free_vld     (free_vld),
        .free_tag     (free_tag),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .ready        (ready),
        .free_count   (free_count)
`ifdef PHYS_TAG_ALLOC_ERR_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check both grant slots of a two-slot grant.
    task automatic chk_pair(input string tag, input int t0, input int t1);
        chk({tag, "_gnt"}, 32'(alloc_gnt), 32'd3);
        chk({tag, "_tag0"}, 32'(alloc_tag[5:0]), 32'(t0));
        chk({tag, "_tag1"}, 32'(alloc_tag[11:6]), 32'(t1));
    endtask

    initial begin
        reset        = 1'b0;
        alloc_req    = 2'b11;
        free_vld     = 2'b00;
        free_tag     = 12'd0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_count", 32'(free_count), 32'd0);
        chk("rst_gnt", 32'(alloc_gnt), 32'd0);
        chk("rst_tag", 32'(alloc_tag), 32'd0);

        // ---- init sequence: ready low for cycles 0..31, requests ignored ----
        reset = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            chk("init_ready", 32'(ready), 32'd0);
            chk("init_gnt", 32'(alloc_gnt), 32'd0);
        end
        @(negedge clk);
        chk("init_done_ready", 32'(ready), 32'd1);
        chk("init_done_count", 32'(free_count), 32'd32);
        #1 chk_pair("first_grant", 32, 33);

        // ---- drain the queue two tags per cycle ----
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("drain_count", 32'(free_count), 32'(32 - 2 * i));
            #1 chk_pair("drain", 32 + 2 * i, 33 + 2 * i);
        end
        @(negedge clk);
        chk("empty_count", 32'(free_count), 32'd0);
        #1 chk("empty_gnt", 32'(alloc_gnt), 32'd0);
        chk("empty_tag", 32'(alloc_tag), 32'd0);

        // ---- single entry, both slots requesting: only slot0 wins ----
        alloc_req = 2'b00;
        free_vld  = 2'b01;
        free_tag  = {6'd0, 6'd63};
        @(negedge clk);
        chk("one_count", 32'(free_count), 32'd1);
        free_vld  = 2'b00;
        alloc_req = 2'b11;
        #1 chk("one_gnt11", 32'(alloc_gnt), 32'd1);
        chk("one_tag11", 32'(alloc_tag), 32'd63);

        // ---- free on slot1 only, same-cycle request sees no bypass ----
        @(negedge clk);
        chk("one_drained", 32'(free_count), 32'd0);
        free_vld  = 2'b10;
        free_tag  = {6'd63, 6'd0};
        alloc_req = 2'b11;
        #1 chk("nobypass_gnt", 32'(alloc_gnt), 32'd0);
        chk("nobypass_tag", 32'(alloc_tag), 32'd0);
        @(negedge clk);
        chk("one_count2", 32'(free_count), 32'd1);
        free_vld  = 2'b00;
        alloc_req = 2'b10;
        #1 chk("one_gnt10", 32'(alloc_gnt), 32'd2);
        chk("one_tag10", 32'(alloc_tag), 32'd4032);
        @(negedge clk);
        chk("one_drained2", 32'(free_count), 32'd0);

        // ---- reset from READY, then reset again at cycle 10 of INIT ----
        reset     = 1'b0;
        alloc_req = 2'b11;
        repeat (2) @(negedge clk);
        chk("rst2_ready", 32'(ready), 32'd0);
        chk("rst2_count", 32'(free_count), 32'd0);
        chk("rst2_gnt", 32'(alloc_gnt), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("midinit_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midinit_rst_ready", 32'(ready), 32'd0);
        chk("midinit_rst_count", 32'(free_count), 32'd0);
        reset = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            chk("reinit_ready", 32'(ready), 32'd0);
        end
        @(negedge clk);
        chk("reinit_done_ready", 32'(ready), 32'd1);
        chk("reinit_done_count", 32'(free_count), 32'd32);

        // ---- checkpoint: save captures head after this cycle's grants ----
        ckpt_save = 1'b1;
        #1 chk_pair("save_grant", 32, 33);
        @(negedge clk);
        chk("save_count", 32'(free_count), 32'd30);
        ckpt_save = 1'b0;
        #1 chk_pair("spec_a", 34, 35);
        @(negedge clk);
        chk("spec_a_count", 32'(free_count), 32'd28);
        #1 chk_pair("spec_b", 36, 37);
        @(negedge clk);
        chk("spec_b_count", 32'(free_count), 32'd26);
        ckpt_restore = 1'b1;
        #1 chk("restore_gnt", 32'(alloc_gnt), 32'd0);
        chk("restore_tag", 32'(alloc_tag), 32'd0);
        @(negedge clk);
        chk("recover_ready", 32'(ready), 32'd0);
        chk("recover_count", 32'(free_count), 32'd30);
        ckpt_restore = 1'b0;
        #1 chk("recover_gnt", 32'(alloc_gnt), 32'd0);
        @(negedge clk);
        chk("post_recover_ready", 32'(ready), 32'd1);
        chk("post_recover_count", 32'(free_count), 32'd30);
        alloc_req = 2'b01;
        #1 chk("after_restore_gnt", 32'(alloc_gnt), 32'd1);
        chk("after_restore_tag", 32'(alloc_tag), 32'd34);

        // ---- simultaneous free and allocate at count 30 ----
        @(negedge clk);
        chk("pre_free_count", 32'(free_count), 32'd29);
        alloc_req = 2'b00;
        free_vld  = 2'b01;
        free_tag  = {6'd0, 6'd32};
        @(negedge clk);
        chk("count30", 32'(free_count), 32'd30);
        free_vld  = 2'b11;
        free_tag  = {6'd41, 6'd40};
        alloc_req = 2'b11;
        #1 chk_pair("mixed", 35, 36);
        @(negedge clk);
        chk("mixed_count", 32'(free_count), 32'd30);
`ifdef PHYS_TAG_ALLOC_ERR_EN
        chk("err_clear", 32'(err), 32'd0);
`endif

        // ---- overflow: at 31 free two, only slot0 accepted ----
        alloc_req = 2'b00;
        free_vld  = 2'b01;
        free_tag  = {6'd0, 6'd42};
        @(negedge clk);
        chk("count31", 32'(free_count), 32'd31);
        free_vld = 2'b11;
        free_tag = {6'd44, 6'd43};
        @(negedge clk);
        chk("overflow_count", 32'(free_count), 32'd32);
`ifdef PHYS_TAG_ALLOC_ERR_EN
        chk("overflow_err", 32'(err), 32'd1);
`endif
        free_vld = 2'b00;

        // ---- drain full queue: wrapped order, 44 must be absent ----
        for (int v = 37; v <= 63; v++) exp_tags.push_back(v);
        exp_tags.push_back(32);
        exp_tags.push_back(40);
        exp_tags.push_back(41);
        exp_tags.push_back(42);
        exp_tags.push_back(43);
        alloc_req = 2'b11;
        for (int i = 0; i < 16; i++) begin
            #1 chk_pair("final_drain", exp_tags[2 * i], exp_tags[2 * i + 1]);
            @(negedge clk);
            chk("final_drain_count", 32'(free_count), 32'(30 - 2 * i));
        end
        #1 chk("final_empty_gnt", 32'(alloc_gnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
